// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler:
// FSM state encodings and the packed FIFO entry layout {taken, pc, target}.
package bp_update_scheduler_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Entry layout: target in the low PC-width bits, pc above it,
  // taken flag as the MSB.
  localparam int ENT_TGT_LSB = 0;

  function automatic int ent_pc_lsb(input int pcw);
    return pcw;
  endfunction

  function automatic int ent_taken_bit(input int pcw);
    return 2 * pcw;
  endfunction

  function automatic int ent_width(input int pcw);
    return 2 * pcw + 1;
  endfunction

endpackage

// File: rtl/bp_update_scheduler_fifo.sv
// Synchronous update-queue FIFO with full/empty flags.
// Ports: clk, reset, push/push_data, pop/pop_data, full, empty.
// A push while full is taken only when a pop happens in the same cycle.
module bp_update_fifo
  import bp_update_scheduler_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates branch resolutions into a queue feeding the predictor update
// port, tracks in-flight predictions (fetch_stall) and runs the drain FSM.
// Ports: clk, reset, req_* (per-requester resolution bus), req_ready grant,
// pred_issue, flush, drain_req/drain_done, upd_* predictor update,
// fetch_stall, inflight_count, pop_stall (test hook: holds the queue, tie 0).
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int PC_WIDTH     = 64,
  parameter int NUM_REQ      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_taken,
  input  logic [NUM_REQ-1:0]            req_predicted,
  input  logic [NUM_REQ*PC_WIDTH-1:0]   req_pc,
  input  logic [NUM_REQ*PC_WIDTH-1:0]   req_target,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          pred_issue,
  input  logic                          flush,
  input  logic                          drain_req,
  output logic                          drain_done,
  output logic                          upd_taken,
  output logic                          upd_not_taken,
  output logic [PC_WIDTH-1:0]           upd_pc,
  output logic [PC_WIDTH-1:0]           upd_target,
  output logic                          fetch_stall,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count,
  input  logic                          pop_stall
);

  localparam int CW   = $clog2(MAX_INFLIGHT+1);
  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int EW   = ent_width(PC_WIDTH);
  localparam int TB   = ent_taken_bit(PC_WIDTH);
  localparam int PL   = ent_pc_lsb(PC_WIDTH);
  localparam int TL   = ENT_TGT_LSB;

  state_t              state;
  state_t              state_nxt;
  logic [PTRW-1:0]     rr_ptr;
  logic [PTRW-1:0]     rr_nxt;
  logic [CW-1:0]       cnt;
  logic                full;
  logic                empty;
  logic                pop;
  logic                can_grant;
  logic                found;
  logic [NUM_REQ-1:0]  grant;
  logic                g_taken;
  logic                g_pred;
  logic [PC_WIDTH-1:0] g_pc;
  logic [PC_WIDTH-1:0] g_tgt;
  logic [EW-1:0]       push_data;
  logic [EW-1:0]       pop_data;
  logic                dec;

  assign pop = !empty && !pop_stall;

  // A full queue still accepts when it pops in the same cycle.
  assign can_grant = (state == RUN) && !flush && (!full || pop);

  // Round-robin: search from rr_ptr upward, wrapping.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    rr_nxt  = rr_ptr;
    g_taken = 1'b0;
    g_pred  = 1'b0;
    g_pc    = '0;
    g_tgt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (can_grant && !found && req_valid[r] &&
            r == (int'(rr_ptr) + k) % NUM_REQ) begin
          found    = 1'b1;
          grant[r] = 1'b1;
          rr_nxt   = PTRW'((r + 1) % NUM_REQ);
          g_taken  = req_taken[r];
          g_pred   = req_predicted[r];
          g_pc     = req_pc[r*PC_WIDTH +: PC_WIDTH];
          g_tgt    = req_target[r*PC_WIDTH +: PC_WIDTH];
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    push_data                 = '0;
    push_data[TB]             = g_taken;
    push_data[PL +: PC_WIDTH] = g_pc;
    push_data[TL +: PC_WIDTH] = g_tgt;
  end

  bp_update_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (found),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_taken     <= 1'b0;
      upd_not_taken <= 1'b0;
      upd_pc        <= '0;
      upd_target    <= '0;
    end else begin
      upd_taken     <= pop && pop_data[TB];
      upd_not_taken <= pop && !pop_data[TB];
      if (pop) begin
        upd_pc     <= pop_data[PL +: PC_WIDTH];
        upd_target <= pop_data[TL +: PC_WIDTH];
      end
    end
  end

  assign dec = found && g_pred;

  assign fetch_stall = (cnt == CW'(MAX_INFLIGHT)) ||
                       (state != RUN);

  // Simultaneous issue and retire cancel even when stalled.
  always_ff @(posedge clk) begin
    if (reset)                          cnt <= '0;
    else if (flush)                     cnt <= '0;
    else if (pred_issue && dec)         cnt <= cnt;
    else if (pred_issue && !fetch_stall) cnt <= cnt + CW'(1);
    else if (dec && cnt != '0)          cnt <= cnt - CW'(1);
  end

  assign inflight_count = cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty && !upd_taken && !upd_not_taken &&
            cnt == '0)
          state_nxt = DONE;
      end
      DONE: begin
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign drain_done = (state == DONE);

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomised bench for bp_update_scheduler: a queue-based reference model
// predicts grants, counter and FSM; a scoreboard checks every update pulse.
module tb_bp_update_scheduler;

  localparam int PCW = 64;
  localparam int NR  = 2;
  localparam int FD  = 4;
  localparam int MI  = 4;
  localparam int CW  = $clog2(MI+1);

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_taken;
  logic [NR-1:0]     req_predicted;
  logic [NR*PCW-1:0] req_pc;
  logic [NR*PCW-1:0] req_target;
  logic [NR-1:0]     req_ready;
  logic              pred_issue;
  logic              flush;
  logic              drain_req;
  logic              drain_done;
  logic              upd_taken;
  logic              upd_not_taken;
  logic [PCW-1:0]    upd_pc;
  logic [PCW-1:0]    upd_target;
  logic              fetch_stall;
  logic [CW-1:0]     inflight_count;
  logic              pop_stall;

  bp_update_scheduler #(
    .PC_WIDTH     (PCW),
    .NUM_REQ      (NR),
    .FIFO_DEPTH   (FD),
    .MAX_INFLIGHT (MI)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_taken      (req_taken),
    .req_predicted  (req_predicted),
    .req_pc         (req_pc),
    .req_target     (req_target),
    .req_ready      (req_ready),
    .pred_issue     (pred_issue),
    .flush          (flush),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .upd_taken      (upd_taken),
    .upd_not_taken  (upd_not_taken),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .fetch_stall    (fetch_stall),
    .inflight_count (inflight_count),
    .pop_stall      (pop_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    logic [63:0] pc;
    logic [63:0] tgt;
    int          due;
  } upd_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   armed    = 1'b0;
  upd_t sb[$];
  upd_t m_fifo[$];
  int   m_state  = 0;
  int   m_cnt    = 0;
  int   m_ptr    = 0;
  bit   m_upd_on = 1'b0;
  logic [NR-1:0] m_gnt = '0;
  logic [63:0] last_pc  = '0;
  logic [63:0] last_tgt = '0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: evaluated at negedge with inputs stable.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    bit   popn;
    bit   room;
    bit   dec;
    bit   stalled;
    int   w;
    int   ns;
    upd_t e;
    stalled = (m_cnt == MI) || (m_state != 0);
    if (armed) begin
      check("inflight", 64'(inflight_count), 64'(m_cnt));
      check("fetch_stall", 64'(fetch_stall), 64'(stalled));
      check("drain_done", 64'(drain_done), 64'(m_state == 2));
    end
    popn = (m_fifo.size() > 0) && !pop_stall;
    room = (m_fifo.size() < FD) || popn;
    w = -1;
    if (m_state == 0 && !flush && room)
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (w < 0 && 1'(req_valid >> idx)) w = idx;
      end
    exp_rdy = (w >= 0) ? (NR'(1) << w) : '0;
    if (armed && !reset)
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (reset) begin
      m_gnt    = '0;
      m_fifo.delete();
      m_state  = 0;
      m_cnt    = 0;
      m_ptr    = 0;
      m_upd_on = 1'b0;
      armed   <= 1'b1;
    end else begin
      m_gnt = exp_rdy;
      ns = m_state;
      case (m_state)
        0: if (drain_req) ns = 1;
        1: if (m_fifo.size() == 0 && !m_upd_on && m_cnt == 0)
             ns = 2;
        default: if (!drain_req) ns = 0;
      endcase
      if (popn) begin
        e = m_fifo.pop_front();
        e.due = cyc + 1;
        sb.push_back(e);
      end
      m_upd_on = popn;
      dec = 1'b0;
      if (w >= 0) begin
        e.taken = 1'(req_taken >> w);
        e.pc    = PCW'(req_pc >> (w*PCW));
        e.tgt   = PCW'(req_target >> (w*PCW));
        e.due   = 0;
        m_fifo.push_back(e);
        m_ptr = (w + 1) % NR;
        dec = 1'(req_predicted >> w);
      end
      if (flush)                         m_cnt = 0;
      else if (pred_issue && dec)        m_cnt = m_cnt;
      else if (pred_issue && !stalled)   m_cnt = m_cnt + 1;
      else if (dec && m_cnt > 0)         m_cnt = m_cnt - 1;
      m_state = ns;
    end
  end

  // Monitor: consumes scoreboard entries as update pulses appear.
  always @(negedge clk) begin
    upd_t e;
    if (armed) begin
      check("upd_exclusive", 64'(upd_taken & upd_not_taken), 64'(0));
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL upd_missing: got none expected pc %0h (cycle %0d)",
                 sb[0].pc, cyc);
        void'(sb.pop_front());
      end
      if (upd_taken || upd_not_taken) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL upd_unexpected: got pc %0h expected none (cycle %0d)",
                   upd_pc, cyc);
        end else begin
          e = sb.pop_front();
          check("upd_taken", 64'(upd_taken), 64'(e.taken));
          check("upd_pc", upd_pc, e.pc);
          check("upd_target", upd_target, e.tgt);
          check("upd_cycle", 64'(cyc), 64'(e.due));
          last_pc  = e.pc;
          last_tgt = e.tgt;
        end
      end else begin
        check("upd_pc_hold", upd_pc, last_pc);
        check("upd_target_hold", upd_target, last_tgt);
      end
      if (reset) begin
        last_pc  = '0;
        last_tgt = '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid  = req_valid & ~m_gnt;
    pred_issue = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic offer(input int r, input bit tk, input bit pd,
                       input logic [PCW-1:0] pc,
                       input logic [PCW-1:0] tg);
    logic [NR-1:0]     b;
    logic [NR*PCW-1:0] m;
    b = NR'(1) << r;
    if ((req_valid & b) == '0) begin
      req_valid     = req_valid | b;
      req_taken     = tk ? (req_taken | b) : (req_taken & ~b);
      req_predicted = pd ? (req_predicted | b) : (req_predicted & ~b);
      m = (NR*PCW)'({PCW{1'b1}}) << (r*PCW);
      req_pc     = (req_pc & ~m) | ((NR*PCW)'(pc) << (r*PCW));
      req_target = (req_target & ~m) | ((NR*PCW)'(tg) << (r*PCW));
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic offer_rnd(input int r, input bit pd);
    offer(r, 1'($urandom), pd, rnd64(), rnd64());
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_taken = '0;
    req_predicted = '0;
    req_pc = '0;
    req_target = '0;
    pred_issue = 1'b0;
    flush = 1'b0;
    drain_req = 1'b0;
    pop_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // First transfer right out of reset.
    offer(0, 1'b1, 1'b0, 64'h10, 64'h40);
    repeat (5) tick();
    // Two requesters contending.
    for (int i = 0; i < 6; i++) begin
      offer_rnd(0, 1'($urandom));
      offer_rnd(1, 1'($urandom));
      tick();
    end
    repeat (6) tick();
    // Fill the queue while held, offer more, then release.
    pop_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer_rnd(i % 2, 1'b0);
      tick();
    end
    pop_stall = 1'b0;
    offer_rnd(0, 1'b0);
    offer_rnd(1, 1'b0);
    repeat (10) tick();
    // Saturate in-flight counter.
    for (int i = 0; i < 5; i++) begin
      pred_issue = 1'b1;
      tick();
    end
    pred_issue = 1'b1;
    offer_rnd(0, 1'b1);
    tick();
    offer_rnd(1, 1'b1);
    tick();
    repeat (3) tick();
    // Flush with pred_issue while updates are queued.
    pop_stall = 1'b1;
    offer_rnd(0, 1'b0);
    tick();
    offer_rnd(1, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    pred_issue = 1'b1;
    tick();
    pop_stall = 1'b0;
    repeat (5) tick();
    // Drain with two queued entries and one in flight.
    pop_stall = 1'b1;
    offer_rnd(0, 1'b0);
    tick();
    offer_rnd(1, 1'b0);
    pred_issue = 1'b1;
    tick();
    tick();
    drain_req = 1'b1;
    tick();
    pop_stall = 1'b0;
    offer_rnd(0, 1'b1);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    repeat (4) tick();
    drain_req = 1'b0;
    repeat (4) tick();
    // Randomised traffic, including mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) offer_rnd(0, 1'($urandom));
      if ($urandom_range(0, 2) == 0) offer_rnd(1, 1'($urandom));
      pred_issue = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) pop_stall = ~pop_stall;
      if ($urandom_range(0, 40) == 0) drain_req = ~drain_req;
      reset = ($urandom_range(0, 150) == 0);
      tick();
    end
    reset = 1'b0;
    pop_stall = 1'b0;
    drain_req = 1'b0;
    flush = 1'b1;
    tick();
    repeat (20) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
